// File: rtl/window_compositor.sv
// window_compositor
// ------------------
// Multi-layer window compositor in the VGA pixel path. Each screen pixel
// (sx, sy) is tested against up to NUM_LAYERS rectangular windows. Every
// renderer receives its window-local coordinates. The colours the renderers
// return are realigned with a delay line. The highest-priority opaque layer
// (lowest index) drives the registered R/G/B outputs.
//
// Window geometry is held in shadow registers that reload only on frame_stb,
// so a window never moves in the middle of a frame.
//
// Optional feature macro: COLOR_KEY_EN
//   defined   : a layer pixel equal to KEY_COLOR is transparent.
//   undefined : every hit pixel is opaque and no key comparators exist.
//
// Ports
//   vga_pix_clk      pixel clock (only clock)
//   rst              synchronous active-high reset
//   sx, sy           screen coordinates
//   display_enabled  visible-area flag
//   frame_stb        one-cycle pulse at start of vertical blanking
//   cfg_en           per-layer enable
//   cfg_x_off/y_off  packed window left/top edges (layer i at [i*W +: W])
//   cfg_w/h          packed window width/height
//   win_sx/win_sy    registered window-local coordinates per layer
//   win_en           registered per-layer hit flags
//   win_frame_stb    frame_stb delayed one cycle
//   layer_rgb        packed {R,G,B} per layer from the renderers
//   R, G, B          registered output colour
//   de_out           display_enabled aligned with R/G/B
//   frame_stb_out    frame_stb aligned with R/G/B
module window_compositor #(
   parameter int          H_ADDR_WIDTH  = 10,
   parameter int          V_ADDR_WIDTH  = 10,
   parameter int          NUM_LAYERS    = 4,
   parameter int          LAYER_LATENCY = 2,
   parameter logic [11:0] BG_COLOR      = 12'h000,
   parameter logic [11:0] KEY_COLOR     = 12'hF0F
) (
   input  logic                             vga_pix_clk,
   input  logic                             rst,
   input  logic [H_ADDR_WIDTH-1:0]          sx,
   input  logic [V_ADDR_WIDTH-1:0]          sy,
   input  logic                             display_enabled,
   input  logic                             frame_stb,
   input  logic [NUM_LAYERS-1:0]            cfg_en,
   input  logic [NUM_LAYERS*H_ADDR_WIDTH-1:0] cfg_x_off,
   input  logic [NUM_LAYERS*V_ADDR_WIDTH-1:0] cfg_y_off,
   input  logic [NUM_LAYERS*H_ADDR_WIDTH-1:0] cfg_w,
   input  logic [NUM_LAYERS*V_ADDR_WIDTH-1:0] cfg_h,
   output logic [NUM_LAYERS*H_ADDR_WIDTH-1:0] win_sx,
   output logic [NUM_LAYERS*V_ADDR_WIDTH-1:0] win_sy,
   output logic [NUM_LAYERS-1:0]            win_en,
   output logic                             win_frame_stb,
   input  logic [NUM_LAYERS*12-1:0]         layer_rgb,
   output logic [3:0]                       R,
   output logic [3:0]                       G,
   output logic [3:0]                       B,
   output logic                             de_out,
   output logic                             frame_stb_out
);

   localparam int HW = H_ADDR_WIDTH;
   localparam int VW = V_ADDR_WIDTH;
   localparam int NL = NUM_LAYERS;
   // Delay-line word: {frame_stb, display_enabled, hit mask}
   localparam int DW = NL + 2;

   logic [NL-1:0]    sh_en;
   logic [NL*HW-1:0] sh_x_off;
   logic [NL*HW-1:0] sh_w;
   logic [NL*VW-1:0] sh_y_off;
   logic [NL*VW-1:0] sh_h;

   // Shadow geometry: reset clears everything (all layers disabled), and a
   // frame_stb copies the live cfg_* so the change applies from the next pixel.
   always_ff @(posedge vga_pix_clk) begin
      if (rst) begin
         sh_en    <= '0;
         sh_x_off <= '0;
         sh_w     <= '0;
         sh_y_off <= '0;
         sh_h     <= '0;
      end else if (frame_stb) begin
         sh_en    <= cfg_en;
         sh_x_off <= cfg_x_off;
         sh_w     <= cfg_w;
         sh_y_off <= cfg_y_off;
         sh_h     <= cfg_h;
      end
   end

   logic [NL-1:0]    hit;
   logic [NL*HW-1:0] loc_x;
   logic [NL*VW-1:0] loc_y;

   // Per-layer hit test. The window end is computed one bit wider than the
   // coordinates so a window reaching past the screen edge cannot wrap to a
   // small value. A zero width or height gives an empty range.
   for (genvar i = 0; i < NL; i++) begin : g_hit
      logic [HW-1:0] x_off;
      logic [HW-1:0] w;
      logic [VW-1:0] y_off;
      logic [VW-1:0] h;
      logic [HW:0]   x_end;
      logic [VW:0]   y_end;
      logic          in_x;
      logic          in_y;

      assign x_off = sh_x_off[i*HW +: HW];
      assign w     = sh_w[i*HW +: HW];
      assign y_off = sh_y_off[i*VW +: VW];
      assign h     = sh_h[i*VW +: VW];
      assign x_end = {1'b0, x_off} + {1'b0, w};
      assign y_end = {1'b0, y_off} + {1'b0, h};
      assign in_x  = (sx >= x_off) && ({1'b0, sx} < x_end);
      assign in_y  = (sy >= y_off) && ({1'b0, sy} < y_end);
      assign hit[i] = display_enabled & sh_en[i] & in_x & in_y;
      assign loc_x[i*HW +: HW] = hit[i] ? (sx - x_off) : '0;
      assign loc_y[i*VW +: VW] = hit[i] ? (sy - y_off) : '0;
   end

   logic de_s1;

   // First pipeline stage: window-local coordinates handed to the renderers.
   always_ff @(posedge vga_pix_clk) begin
      if (rst) begin
         win_sx        <= '0;
         win_sy        <= '0;
         win_en        <= '0;
         win_frame_stb <= 1'b0;
         de_s1         <= 1'b0;
      end else begin
         win_sx        <= loc_x;
         win_sy        <= loc_y;
         win_en        <= hit;
         win_frame_stb <= frame_stb;
         de_s1         <= display_enabled;
      end
   end

   logic [DW-1:0] dly [LAYER_LATENCY];

   // Delay line matching the renderer latency, so the hit mask and strobes
   // line up with the layer_rgb they belong to. Cleared on reset so no stale
   // de_out or frame_stb_out leaks out afterwards.
   always_ff @(posedge vga_pix_clk) begin
      if (rst) begin
         for (int k = 0; k < LAYER_LATENCY; k++) begin
            dly[k] <= '0;
         end
      end else begin
         dly[0] <= {win_frame_stb, de_s1, win_en};
         for (int k = 1; k < LAYER_LATENCY; k++) begin
            dly[k] <= dly[k-1];
         end
      end
   end

   logic [NL-1:0] hit_d;
   logic          de_d;
   logic          fs_d;
   logic [NL-1:0] opaque;
   logic [11:0]   pix;

   assign {fs_d, de_d, hit_d} = dly[LAYER_LATENCY-1];

`ifdef COLOR_KEY_EN
   for (genvar i = 0; i < NL; i++) begin : g_key
      assign opaque[i] = (layer_rgb[i*12 +: 12] != KEY_COLOR);
   end
`else
   logic unused_key;
   assign opaque     = '1;
   assign unused_key = ^KEY_COLOR;
`endif

   // Priority select: scanning from the highest index down lets the lowest
   // opaque hit index overwrite the others. Outside the visible area the hit
   // mask is empty and the result is black.
   always_comb begin
      pix = de_d ? BG_COLOR : 12'h000;
      for (int i = NL - 1; i >= 0; i--) begin
         if (hit_d[i] && opaque[i]) begin
            pix = layer_rgb[i*12 +: 12];
         end
      end
   end

   // Registered colour output.
   always_ff @(posedge vga_pix_clk) begin
      if (rst) begin
         R             <= 4'h0;
         G             <= 4'h0;
         B             <= 4'h0;
         de_out        <= 1'b0;
         frame_stb_out <= 1'b0;
      end else begin
         {R, G, B}     <= pix;
         de_out        <= de_d;
         frame_stb_out <= fs_d;
      end
   end

endmodule

// File: tb/tb_window_compositor.sv
// Testbench for window_compositor: directed vector table, hand-written
// frame-boundary/reset sequences and a randomized run, all checked against a
// per-cycle history model of the compositor's behaviour.
module tb_window_compositor;

   localparam int          HW   = 10;
   localparam int          VW   = 10;
   localparam int          NL   = 4;
   localparam int          LAT  = 2;
   localparam logic [11:0] BG   = 12'h000;
   localparam logic [11:0] KEY  = 12'hF0F;
   localparam int          MAXC = 8000;

   typedef struct packed {
      logic [NL-1:0]        en;
      logic [NL-1:0][9:0]   xo;
      logic [NL-1:0][9:0]   yo;
      logic [NL-1:0][9:0]   w;
      logic [NL-1:0][9:0]   h;
   } cfg_t;

   typedef struct packed {
      logic [9:0]          sx;
      logic [9:0]          sy;
      logic                de;
      logic                fs;
      logic                rst;
      cfg_t                cfg;
      logic [NL-1:0][11:0] rgb;
   } hist_t;

   typedef struct {
      bit          load;
      cfg_t        cfg;
      int          sx;
      int          sy;
      logic [11:0] rgb0;
      logic [11:0] rgb1;
      logic [1:0]  e_en;
      int          e_wsx;
      int          e_wsy;
      logic [11:0] e_rgb;
   } vec_t;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic                rst;
   logic [HW-1:0]       sx;
   logic [VW-1:0]       sy;
   logic                display_enabled;
   logic                frame_stb;
   logic [NL-1:0]       cfg_en;
   logic [NL*HW-1:0]    cfg_x_off;
   logic [NL*VW-1:0]    cfg_y_off;
   logic [NL*HW-1:0]    cfg_w;
   logic [NL*VW-1:0]    cfg_h;
   logic [NL*HW-1:0]    win_sx;
   logic [NL*VW-1:0]    win_sy;
   logic [NL-1:0]       win_en;
   logic                win_frame_stb;
   logic [NL*12-1:0]    layer_rgb;
   logic [3:0]          R;
   logic [3:0]          G;
   logic [3:0]          B;
   logic                de_out;
   logic                frame_stb_out;

   window_compositor #(
      .H_ADDR_WIDTH (HW),
      .V_ADDR_WIDTH (VW),
      .NUM_LAYERS   (NL),
      .LAYER_LATENCY(LAT),
      .BG_COLOR     (BG),
      .KEY_COLOR    (KEY)
   ) dut (
      .vga_pix_clk    (clock),
      .rst            (rst),
      .sx             (sx),
      .sy             (sy),
      .display_enabled(display_enabled),
      .frame_stb      (frame_stb),
      .cfg_en         (cfg_en),
      .cfg_x_off      (cfg_x_off),
      .cfg_y_off      (cfg_y_off),
      .cfg_w          (cfg_w),
      .cfg_h          (cfg_h),
      .win_sx         (win_sx),
      .win_sy         (win_sy),
      .win_en         (win_en),
      .win_frame_stb  (win_frame_stb),
      .layer_rgb      (layer_rgb),
      .R              (R),
      .G              (G),
      .B              (B),
      .de_out         (de_out),
      .frame_stb_out  (frame_stb_out)
   );

   int total_checks = 0;
   int bad_checks   = 0;
   int cyc          = 0;

   hist_t hist [MAXC];
   cfg_t  sh   [MAXC];

   cfg_t                cur;
   int                  d_sx;
   int                  d_sy;
   logic                d_de;
   logic                d_fs;
   logic                d_rst;
   logic [NL-1:0][11:0] d_rgb;

   vec_t vt [16];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total_checks++;
      if (act !== exp) begin
         bad_checks++;
         $display("[TB] FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
      end
   endtask

   function automatic cfg_t mk(bit e0, int x0, int y0, int w0, int h0,
                               bit e1, int x1, int y1, int w1, int h1);
      cfg_t c;
      c = '0;
      c.en[0] = e0; c.xo[0] = 10'(x0); c.yo[0] = 10'(y0); c.w[0] = 10'(w0); c.h[0] = 10'(h0);
      c.en[1] = e1; c.xo[1] = 10'(x1); c.yo[1] = 10'(y1); c.w[1] = 10'(w1); c.h[1] = 10'(h1);
      return c;
   endfunction

   function automatic cfg_t rand_cfg();
      cfg_t c;
      for (int i = 0; i < NL; i++) begin
         c.en[i] = 1'($urandom_range(0, 1));
         c.xo[i] = 10'($urandom_range(0, 1023));
         c.yo[i] = 10'($urandom_range(0, 1023));
         c.w[i]  = ($urandom_range(0, 5) == 0) ? 10'd0 : 10'($urandom_range(1, 1023));
         c.h[i]  = ($urandom_range(0, 5) == 0) ? 10'd0 : 10'($urandom_range(1, 1023));
      end
      return c;
   endfunction

   // Reference: pixel p is inside window i under the geometry in force then.
   function automatic bit hit_of(int p, int i);
      int x, y, xo, yo, w, h;
      x  = int'(hist[p].sx);
      y  = int'(hist[p].sy);
      xo = int'(sh[p].xo[i]);
      yo = int'(sh[p].yo[i]);
      w  = int'(sh[p].w[i]);
      h  = int'(sh[p].h[i]);
      return hist[p].de && sh[p].en[i] && x >= xo && x < xo + w && y >= yo && y < yo + h;
   endfunction

   function automatic bit is_opaque(logic [11:0] c);
`ifdef COLOR_KEY_EN
      return c != KEY;
`else
      return (c === c);
`endif
   endfunction

   // Compare the outputs visible in the current cycle with what the history
   // says they must be: window outputs reflect the previous cycle's pixel,
   // the colour reflects the pixel LAT+2 cycles back with this-cycle-minus-1
   // layer colours, and any reset in between forces zeros.
   task automatic checkOutput();
      int                 j, m, p;
      bit                 zero;
      bit                 found;
      logic [NL-1:0]      e_en;
      logic [NL-1:0][9:0] e_sx;
      logic [NL-1:0][9:0] e_sy;
      logic               e_fs;
      logic               e_de;
      logic               e_fso;
      logic [11:0]        e_rgb;
      if (cyc < 1) return;
      j = cyc - 1;
      e_en = '0; e_sx = '0; e_sy = '0; e_fs = 1'b0;
      if (!hist[j].rst) begin
         for (int i = 0; i < NL; i++) begin
            if (hit_of(j, i)) begin
               e_en[i] = 1'b1;
               e_sx[i] = 10'(int'(hist[j].sx) - int'(sh[j].xo[i]));
               e_sy[i] = 10'(int'(hist[j].sy) - int'(sh[j].yo[i]));
            end
         end
         e_fs = hist[j].fs;
      end
      chk("win_en", 64'(win_en), 64'(e_en));
      chk("win_sx", 64'(win_sx), 64'(e_sx));
      chk("win_sy", 64'(win_sy), 64'(e_sy));
      chk("win_frame_stb", 64'(win_frame_stb), 64'(e_fs));

      m = cyc - 1;
      zero = 1'b0;
      for (int t = m - LAT - 1; t <= m; t++) begin
         if (t < 0 || hist[t].rst) zero = 1'b1;
      end
      e_rgb = 12'h000; e_de = 1'b0; e_fso = 1'b0;
      if (!zero) begin
         p = m - LAT - 1;
         e_de  = hist[p].de;
         e_fso = hist[p].fs;
         e_rgb = e_de ? BG : 12'h000;
         found = 1'b0;
         for (int i = 0; i < NL; i++) begin
            if (!found && hit_of(p, i) && is_opaque(hist[m].rgb[i])) begin
               e_rgb = hist[m].rgb[i];
               found = 1'b1;
            end
         end
      end
      chk("rgb", 64'({R, G, B}), 64'(e_rgb));
      chk("de_out", 64'(de_out), 64'(e_de));
      chk("frame_stb_out", 64'(frame_stb_out), 64'(e_fso));
   endtask

   // One pixel cycle: check the current outputs, then drive and record the
   // next set of inputs on the falling edge.
   task automatic applyStimulus();
      @(negedge clock);
      checkOutput();
      if (cyc >= MAXC) begin
         bad_checks++;
         $display("[TB] FAIL cycle_budget got=%0d want<%0d", cyc, MAXC);
         $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
         $fatal(1, "[TB] cycle budget exhausted");
      end
      rst             = d_rst;
      sx              = 10'(d_sx);
      sy              = 10'(d_sy);
      display_enabled = d_de;
      frame_stb       = d_fs;
      cfg_en          = cur.en;
      cfg_x_off       = cur.xo;
      cfg_y_off       = cur.yo;
      cfg_w           = cur.w;
      cfg_h           = cur.h;
      layer_rgb       = d_rgb;
      hist[cyc] = '{sx: 10'(d_sx), sy: 10'(d_sy), de: d_de, fs: d_fs, rst: d_rst,
                    cfg: cur, rgb: d_rgb};
      if (cyc == 0)              sh[cyc] = '0;
      else if (hist[cyc-1].rst)  sh[cyc] = '0;
      else if (hist[cyc-1].fs)   sh[cyc] = hist[cyc-1].cfg;
      else                       sh[cyc] = sh[cyc-1];
      cyc++;
   endtask

   task automatic pixel(int x, int y);
      d_sx = x; d_sy = y; d_de = 1'b1; d_fs = 1'b0;
   endtask

   task automatic after_edge();
      @(posedge clock);
      #1;
   endtask

   task automatic load_cfg(cfg_t c);
      cur = c; d_fs = 1'b1; d_de = 1'b0; d_sx = 0; d_sy = 0;
      applyStimulus();
      d_fs = 1'b0;
   endtask

   cfg_t c0, c1, c2, c3, c4;
   logic [11:0] key_exp;

   initial begin
      rst = 1'b1; sx = '0; sy = '0; display_enabled = 1'b0; frame_stb = 1'b0;
      cfg_en = '0; cfg_x_off = '0; cfg_y_off = '0; cfg_w = '0; cfg_h = '0; layer_rgb = '0;

      c0 = mk(1, 96, 32, 448, 416, 0, 0, 0, 0, 0);
      c1 = mk(1, 96, 32, 448, 416, 1, 0, 0, 200, 200);
      c2 = mk(0, 96, 32, 448, 416, 1, 0, 0, 200, 200);
      c3 = mk(1, 600, 0, 100, 480, 0, 0, 0, 0, 0);
      c4 = mk(1, 1000, 0, 100, 480, 0, 0, 0, 0, 0);
`ifdef COLOR_KEY_EN
      key_exp = 12'h00F;
`else
      key_exp = 12'hF0F;
`endif
      vt[0]  = '{1, c0,   96,  32, 12'h123, 12'h000, 2'b01,   0,   0, 12'h123};
      vt[1]  = '{0, c0,  543,  32, 12'h123, 12'h000, 2'b01, 447,   0, 12'h123};
      vt[2]  = '{0, c0,  544,  32, 12'h123, 12'h000, 2'b00,   0,   0, BG};
      vt[3]  = '{0, c0,   96, 447, 12'h123, 12'h000, 2'b01,   0, 415, 12'h123};
      vt[4]  = '{0, c0,   96, 448, 12'h123, 12'h000, 2'b00,   0,   0, BG};
      vt[5]  = '{0, c0,   95, 100, 12'h123, 12'h000, 2'b00,   0,   0, BG};
      vt[6]  = '{0, c0,  300, 200, 12'h123, 12'h000, 2'b01, 204, 168, 12'h123};
      vt[7]  = '{1, c1,  100, 100, 12'hF00, 12'h0F0, 2'b11,   4,  68, 12'hF00};
      vt[8]  = '{1, c2,  100, 100, 12'hF00, 12'h0F0, 2'b10,   0,   0, 12'h0F0};
      vt[9]  = '{1, c1,  100, 100, 12'hF0F, 12'h00F, 2'b11,   4,  68, key_exp};
      vt[10] = '{1, c3,  600,  10, 12'h456, 12'h000, 2'b01,   0,  10, 12'h456};
      vt[11] = '{0, c3,  639,  10, 12'h456, 12'h000, 2'b01,  39,  10, 12'h456};
      vt[12] = '{0, c3,    0,  10, 12'h456, 12'h000, 2'b00,   0,   0, BG};
      vt[13] = '{0, c3,   59,  10, 12'h456, 12'h000, 2'b00,   0,   0, BG};
      vt[14] = '{1, c4, 1010,   5, 12'h456, 12'h000, 2'b01,  10,   5, 12'h456};
      vt[15] = '{0, c4,   50,   5, 12'h456, 12'h000, 2'b00,   0,   0, BG};

      cur = c0; d_rgb = '0; d_fs = 1'b0;

      // Reset held for three cycles with the display active.
      d_rst = 1'b1; pixel(100, 100);
      for (int r = 0; r < 3; r++) begin
         applyStimulus();
         after_edge();
         chk("reset_win_en", 64'(win_en), 64'(0));
         chk("reset_rgb", 64'({R, G, B}), 64'(0));
         chk("reset_de_out", 64'(de_out), 64'(0));
      end
      d_rst = 1'b0;

      // cfg is presented but no frame_stb yet: all layers must stay off.
      d_rgb[0] = 12'h777;
      repeat (LAT + 3) applyStimulus();
      after_edge();
      chk("pre_stb_win_en", 64'(win_en), 64'(0));
      chk("pre_stb_rgb", 64'({R, G, B}), 64'(BG));
      chk("pre_stb_de_out", 64'(de_out), 64'(1));

      // Directed vector table.
      for (int v = 0; v < 16; v++) begin
         if (vt[v].load) load_cfg(vt[v].cfg);
         d_rgb = '0;
         d_rgb[0] = vt[v].rgb0;
         d_rgb[1] = vt[v].rgb1;
         pixel(vt[v].sx, vt[v].sy);
         repeat (LAT + 3) applyStimulus();
         after_edge();
         chk($sformatf("vec%0d_en", v), 64'(win_en[1:0]), 64'(vt[v].e_en));
         chk($sformatf("vec%0d_wsx", v), 64'(win_sx[9:0]), 64'(vt[v].e_wsx));
         chk($sformatf("vec%0d_wsy", v), 64'(win_sy[9:0]), 64'(vt[v].e_wsy));
         chk($sformatf("vec%0d_rgb", v), 64'({R, G, B}), 64'(vt[v].e_rgb));
      end

      // Frame-synchronous update: x_off 96 -> 200 only takes hold after frame_stb.
      load_cfg(c0);
      pixel(150, 100);
      applyStimulus(); after_edge();
      chk("fsync_before_en", 64'(win_en[0]), 64'(1));
      chk("fsync_before_wsx", 64'(win_sx[9:0]), 64'(54));
      cur.xo[0] = 10'd200;
      repeat (3) applyStimulus();
      after_edge();
      chk("fsync_ignored_en", 64'(win_en[0]), 64'(1));
      chk("fsync_ignored_wsx", 64'(win_sx[9:0]), 64'(54));
      d_fs = 1'b1;
      applyStimulus(); after_edge();
      chk("fsync_stb_cycle_en", 64'(win_en[0]), 64'(1));
      pixel(150, 100);
      applyStimulus(); after_edge();
      chk("fsync_after_old_x", 64'(win_en[0]), 64'(0));
      pixel(200, 100);
      applyStimulus(); after_edge();
      chk("fsync_after_new_en", 64'(win_en[0]), 64'(1));
      chk("fsync_after_new_wsx", 64'(win_sx[9:0]), 64'(0));

      // Reset in the middle of a frame, coinciding with a frame_stb.
      load_cfg(c0);
      d_rgb = '0; d_rgb[0] = 12'h123;
      pixel(300, 200);
      repeat (LAT + 3) applyStimulus();
      d_rst = 1'b1; d_fs = 1'b1;
      applyStimulus(); after_edge();
      chk("midrst_rgb", 64'({R, G, B}), 64'(0));
      chk("midrst_de_out", 64'(de_out), 64'(0));
      chk("midrst_win_fs", 64'(win_frame_stb), 64'(0));
      d_rst = 1'b0; d_fs = 1'b0;
      repeat (LAT + 3) applyStimulus();
      after_edge();
      chk("midrst_layers_off", 64'(win_en), 64'(0));
      chk("midrst_de_back", 64'(de_out), 64'(1));

      // Randomized run against the history model.
      for (int n = 0; n < 2500; n++) begin
         if ($urandom_range(0, 63) == 0) cur = rand_cfg();
         d_fs  = ($urandom_range(0, 39) == 0);
         d_rst = ($urandom_range(0, 199) == 0);
         d_de  = ($urandom_range(0, 7) != 0);
         d_sx  = $urandom_range(0, 1023);
         d_sy  = $urandom_range(0, 1023);
         for (int i = 0; i < NL; i++) begin
            d_rgb[i] = ($urandom_range(0, 3) == 0) ? KEY : 12'($urandom_range(0, 4095));
         end
         applyStimulus();
      end
      d_rst = 1'b0; d_fs = 1'b0;
      repeat (LAT + 3) applyStimulus();

      $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
      $finish;
   end

endmodule

// File: doc/window_compositor.md
# window_compositor

Parametrised multi-layer window compositor sitting between the VGA timing generator and the game/overlay renderers in the pixel path. It maps raw scan coordinates into up to NUM_LAYERS rectangular windows, hands each renderer its window-local coordinates, and realigns the returned colours with a delay pipeline. It then selects the highest-priority opaque pixel per screen position and drives registered R/G/B. Window geometry is runtime-programmable and takes effect only at frame boundaries, so windows never tear mid-frame.

## Interface
Parameters:
- H_ADDR_WIDTH, 10: width of screen sx and of window geometry fields.
- V_ADDR_WIDTH, 10: width of screen sy and of window geometry fields.
- NUM_LAYERS, 4: number of windows, 1..8; index 0 is highest priority.
- LAYER_LATENCY, 2: renderer latency in cycles from win_* to layer_rgb, ≥1.
- BG_COLOR, 12'h000: {R,G,B} shown inside the visible area where no layer is opaque.
- KEY_COLOR, 12'hF0F: transparent colour key; used only with COLOR_KEY_EN.

Ports:
- vga_pix_clk, in, 1: pixel clock; the only clock.
- rst, in, 1: reset, synchronous, active-high.
- sx, in, H_ADDR_WIDTH: screen x.
- sy, in, V_ADDR_WIDTH: screen y.
- display_enabled, in, 1: visible-area flag.
- frame_stb, in, 1: one-cycle pulse at the start of vertical blanking.
- cfg_en, in, NUM_LAYERS: per-layer enable.
- cfg_x_off, in, NUM_LAYERS*H_ADDR_WIDTH: packed window left edges; layer i occupies bits [i*W +: W].
- cfg_y_off, in, NUM_LAYERS*V_ADDR_WIDTH: packed window top edges.
- cfg_w, in, NUM_LAYERS*H_ADDR_WIDTH: packed window widths.
- cfg_h, in, NUM_LAYERS*V_ADDR_WIDTH: packed window heights.
- win_sx, out, NUM_LAYERS*H_ADDR_WIDTH: window-local x per layer.
- win_sy, out, NUM_LAYERS*V_ADDR_WIDTH: window-local y per layer.
- win_en, out, NUM_LAYERS: pixel lies inside window i.
- win_frame_stb, out, 1: frame_stb delayed 1 cycle.
- layer_rgb, in, NUM_LAYERS*12: packed {R,G,B} returned by the renderers.
- R, out, 4: red. G, out, 4: green. B, out, 4: blue.
- de_out, out, 1: display_enabled aligned with R/G/B.
- frame_stb_out, out, 1: frame_stb aligned with R/G/B.

## Operation
- **Shadow registers.** Shadow copies of cfg_* are loaded on any cycle with frame_stb=1. Between pulses, cfg_* changes are ignored.
- **Reset state.** All shadows are cleared to 0, so every layer is disabled.
- **Hit test, layer i.** hit = display_enabled & en_i & (sx ≥ x_off_i) & (sx < x_off_i + w_i) & (sy ≥ y_off_i) & (sy < y_off_i + h_i).
  - Compute the sums in W+1 bits so that windows touching the screen edge never wrap.
  - w_i = 0 or h_i = 0 means the window is never hit.
- **Local coordinates.** win_sx_i = sx − x_off_i and win_sy_i = sy − y_off_i when hit; otherwise 0.
- **Delay pipeline.** hit mask, display_enabled and frame_stb are carried through a delay line of LAYER_LATENCY cycles so they align with layer_rgb.
- **Selection.** Choose the lowest index i with a delayed hit whose pixel is opaque.
  - Output its layer_rgb.
  - If no such layer and delayed de = 1, output BG_COLOR.
  - If delayed de = 0, output 0.
- **Opacity.** Each layer_rgb slice is sampled only when its delayed hit is set; otherwise it is don't-care.

## Timing
- win_sx, win_sy, win_en and win_frame_stb are registered, 1 cycle after sx/sy.
- layer_rgb is sampled LAYER_LATENCY cycles after the matching win_*.
- R/G/B, de_out and frame_stb_out are registered, with total latency 2 + LAYER_LATENCY cycles from sx/sy.
- Reset values: all outputs 0, and the delay line is cleared to 0, so no spurious de_out or frame_stb_out appears after reset.
- Frame boundary:
  - A cfg change applies to the first pixel after the frame_stb cycle.
  - A frame_stb coinciding with rst is ignored; reset wins.
- Overlapping windows: the lower index always wins.
- Reset mid-frame: outputs are 0 from the next cycle, and layers stay disabled until the next frame_stb.

## Configuration
- Macro: COLOR_KEY_EN.
  - **Defined:** a layer pixel equal to KEY_COLOR is transparent, and selection falls through to the next hit layer, then to BG_COLOR.
  - **Undefined:** every hit pixel is opaque. KEY_COLOR is unused and no comparators are built.

## Test plan
- **Reset:** assert rst 3 cycles during display_enabled=1 -> R/G/B=0, de_out=0, win_en=0 throughout; all layers stay off until the first frame_stb.
- **Single centred window:** layer0 at x_off=96, y_off=32, w=448, h=416, frame_stb pulsed.
  - sx=96, sy=32 -> win_en[0]=1 with win_sx=0, win_sy=0 one cycle later.
  - sx=543 -> win_sx=447.
  - sx=544 -> win_en[0]=0.
  - With layer_rgb[0]=12'h123 -> R/G/B=1,2,3 at 2+LAYER_LATENCY.
- **Priority:** layers 0 and 1 both cover (100,100), layer0=12'hF00, layer1=12'h0F0 -> output 12'hF00. Disable layer0 at the next frame_stb -> 12'h0F0.
- **Frame-synchronous update:** change cfg_x_off[0] from 96 to 200 mid-frame -> the hit window is unchanged until after frame_stb, and the next frame starts at sx=200.
- **Edge/overflow:** x_off=600, w=100 -> hits for sx=600..639 only; no hit at sx=0..59.
- **Colour key:** with COLOR_KEY_EN, layer0=12'hF0F over layer1=12'h00F -> output 12'h00F. Without COLOR_KEY_EN -> output 12'hF0F.
